// File: rtl/common_pkg.sv
// Shared types and constants for the execution back end.
//
// Contents:
//   PREG_TAG_W   width of a physical register tag
//   cdb_t        {valid, tag, data} common data bus broadcast
//   OPC_*/F7_*   RV32 decode constants used by the ALU
//   alu_fn_e     decoded ALU function
//   alu_state_e  ALU execution unit FSM states (exported for debug)
//   alu_decode   decode fields into alu_fn_e
//   alu_compute  single-cycle datapath (MUL is produced by alu_mul_iter)
//
// Optional feature macro: ALU_MUL_EN (decode of MUL, funct7=0000001 funct3=000).
package common_pkg;

    localparam int PREG_TAG_W = 6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef struct packed {
        logic                  valid;
        logic [PREG_TAG_W-1:0] tag;
        logic [31:0]           data;
    } cdb_t;

    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR,
        FN_SRL, FN_SRA, FN_OR, FN_AND, FN_MUL, FN_NONE
    } alu_fn_e;

    typedef enum logic [1:0] {
        IDLE, MUL_BUSY, WB
    } alu_state_e;

    function automatic alu_fn_e alu_decode(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [6:0] funct7);
        alu_fn_e fn;
        fn = FN_NONE;
        if (opcode == OPC_OP && funct7 == F7_MULDIV) begin
            // M-extension encodings: only MUL exists, and only when enabled.
`ifdef ALU_MUL_EN
            if (funct3 == 3'b000) fn = FN_MUL;
`endif
        end else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (funct3)
                // Immediate form carries imm[11:5] in funct7, so it never subtracts.
                3'b000:  fn = (opcode == OPC_OP && funct7[5]) ? FN_SUB : FN_ADD;
                3'b001:  fn = FN_SLL;
                3'b010:  fn = FN_SLT;
                3'b011:  fn = FN_SLTU;
                3'b100:  fn = FN_XOR;
                3'b101:  fn = funct7[5] ? FN_SRA : FN_SRL;
                3'b110:  fn = FN_OR;
                default: fn = FN_AND;
            endcase
        end
        return fn;
    endfunction

    function automatic logic [31:0] alu_compute(input alu_fn_e fn,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (fn)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_SLL:  return a << shamt;
            FN_SLT:  return {31'd0, $signed(a) < $signed(b)};
            FN_SLTU: return {31'd0, a < b};
            FN_XOR:  return a ^ b;
            FN_SRL:  return a >> shamt;
            FN_SRA:  return $unsigned($signed(a) >>> shamt);
            FN_OR:   return a | b;
            FN_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low 32 bits of the product.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start_i          load operands; iteration begins next cycle
//   abort_i          discard the multiply in progress
//   op_a_i, op_b_i   operands sampled on start_i
//   busy_o           iteration in progress (exactly 32 cycles)
//   done_o           last iteration cycle; product_o is final in this cycle
//   product_o        running sum including the current iteration's addend
module alu_mul_iter
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] acc_step;

    // Product is exposed combinationally so the owner can capture it on the
    // same edge that retires the 32nd iteration.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == 5'd31);
    assign product_o = acc_step;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = 5'd0;
        end else if (start_i) begin
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            acc_d    = 32'd0;
            cnt_d    = 5'd0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            busy_d   = (cnt_q != 5'd31);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer ALU execution unit with a registered CDB broadcast.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_issue_valid / alu_ex_ready  issue handshake
//   alu_op_a, alu_op_b              operands (op_b already immediate-muxed)
//   alu_opcode/funct3/funct7        RV32 decode fields
//   alu_p_dest                      destination physical register tag
//   flush                           discard all in-flight work
//   cdb_grant                       arbiter accepted the current broadcast
//   cdb_out                         {valid, tag, data} broadcast
//   dbg_state_o                     current FSM state
//
// Optional feature macro: ALU_MUL_EN adds MUL via alu_mul_iter (32 busy cycles).
//
// Handshake: an instruction transfers on a rising edge where alu_issue_valid
// and alu_ex_ready are both high and flush is low. cdb_out.valid stays high
// with stable tag/data until a cycle with cdb_grant high; that edge retires it.
// alu_ex_ready depends combinationally on cdb_grant so a granted result can be
// replaced by the next one without a bubble.
module alu_exec_unit
    import common_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_issue_valid,
    input  logic [31:0]           alu_op_a,
    input  logic [31:0]           alu_op_b,
    input  logic [6:0]            alu_opcode,
    input  logic [2:0]            alu_funct3,
    input  logic [6:0]            alu_funct7,
    input  logic [PREG_TAG_W-1:0] alu_p_dest,
    output logic                  alu_ex_ready,
    input  logic                  flush,
    input  logic                  cdb_grant,
    output cdb_t                  cdb_out,
    output alu_state_e            dbg_state_o
);

    alu_state_e  state_q, state_d;
    cdb_t        cdb_q, cdb_d;
    alu_fn_e     fn;
    logic [31:0] result;
    logic        accept;

    assign fn     = alu_decode(alu_opcode, alu_funct3, alu_funct7);
    assign result = alu_compute(fn, alu_op_a, alu_op_b);

    assign alu_ex_ready = !reset && ((state_q == IDLE) || (state_q == WB && cdb_grant));
    // A transfer offered in a flush cycle belongs to the squashed path.
    assign accept       = alu_issue_valid && alu_ex_ready && !flush;

    assign cdb_out     = cdb_q;
    assign dbg_state_o = state_q;

`ifdef ALU_MUL_EN
    logic                  mul_start;
    logic                  mul_busy;
    logic                  mul_done;
    logic [31:0]           mul_product;
    logic [PREG_TAG_W-1:0] mul_tag_q, mul_tag_d;

    assign mul_start = accept && (fn == FN_MUL);
    assign mul_tag_d = mul_start ? alu_p_dest : mul_tag_q;

    alu_mul_iter u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .abort_i   (flush),
        .op_a_i    (alu_op_a),
        .op_b_i    (alu_op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) mul_tag_q <= '0;
        else       mul_tag_q <= mul_tag_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cdb_d   = cdb_q;

        // Granted broadcast retires; a same-cycle transfer below overrides this.
        if (state_q == WB && cdb_grant) begin
            state_d = IDLE;
            cdb_d   = '0;
        end

`ifdef ALU_MUL_EN
        if (state_q == MUL_BUSY) begin
            if (mul_done) begin
                state_d = WB;
                cdb_d   = '{valid: 1'b1, tag: mul_tag_q, data: mul_product};
            end else if (!mul_busy) begin
                state_d = IDLE;
            end
        end
`endif

        if (accept) begin
            state_d = WB;
            cdb_d   = '{valid: 1'b1, tag: alu_p_dest, data: result};
`ifdef ALU_MUL_EN
            if (fn == FN_MUL) begin
                state_d = MUL_BUSY;
                cdb_d   = '0;
            end
`endif
        end

        if (flush) begin
            state_d = IDLE;
            cdb_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cdb_q   <= '0;
        end else begin
            state_q <= state_d;
            cdb_q   <= cdb_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import common_pkg::*;

    localparam int W = PREG_TAG_W + 32;

    logic                  clk;
    logic                  reset;
    logic                  alu_issue_valid;
    logic [31:0]           alu_op_a;
    logic [31:0]           alu_op_b;
    logic [6:0]            alu_opcode;
    logic [2:0]            alu_funct3;
    logic [6:0]            alu_funct7;
    logic [PREG_TAG_W-1:0] alu_p_dest;
    logic                  alu_ex_ready;
    logic                  flush;
    logic                  cdb_grant;
    cdb_t                  cdb_out;
    alu_state_e            dbg_state_o;

    alu_exec_unit dut (
        .clk             (clk),
        .reset           (reset),
        .alu_issue_valid (alu_issue_valid),
        .alu_op_a        (alu_op_a),
        .alu_op_b        (alu_op_b),
        .alu_opcode      (alu_opcode),
        .alu_funct3      (alu_funct3),
        .alu_funct7      (alu_funct7),
        .alu_p_dest      (alu_p_dest),
        .alu_ex_ready    (alu_ex_ready),
        .flush           (flush),
        .cdb_grant       (cdb_grant),
        .cdb_out         (cdb_out),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           mul_left;
    logic [W-1:0] mul_item;
    int           n_vec;
    int           n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cdb_word(input logic v, input int t, input logic [31:0] d);
        return 64'({v, PREG_TAG_W'(t), d});
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ref_is_mul(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
`ifdef ALU_MUL_EN
        return (opc == 7'h33) && (f7 == 7'h01) && (f3 == 3'd0);
`else
        return (opc == 7'h33) && (f7 == 7'h01) && (f3 == 3'd0) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [6:0] opc, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] a,
                                               input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        if (opc != 7'h33 && opc != 7'h13) return 32'd0;
        if (opc == 7'h33 && f7 == 7'h01) return ref_is_mul(opc, f3, f7) ? a * b : 32'd0;
        case (f3)
            3'd0: return (opc == 7'h33 && f7[5]) ? a - b : a + b;
            3'd1: return a * (32'd1 << sh);
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                fill = (f7[5] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Called ~1 time unit after a rising edge. Drives one cycle, checks the
    // DUT against the model mid-cycle, crosses the edge, advances the model.
    task automatic cycle(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input int tag, input logic g, input logic fl, input string name);
        bit ready_exp;
        alu_issue_valid = v;
        alu_opcode      = opc;
        alu_funct3      = f3;
        alu_funct7      = f7;
        alu_op_a        = a;
        alu_op_b        = b;
        alu_p_dest      = PREG_TAG_W'(tag);
        cdb_grant       = g;
        flush           = fl;
        #2;
        ready_exp = (mul_left == 0) && (exp_q.size() == 0 || g);
        check({name, ".ready"}, 64'(alu_ex_ready), 64'(ready_exp));
        check({name, ".valid"}, 64'(cdb_out.valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check({name, ".tag_data"}, 64'({cdb_out.tag, cdb_out.data}), 64'(exp_q[0]));
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            mul_left = 0;
        end else begin
            if (exp_q.size() != 0 && g) void'(exp_q.pop_front());
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) exp_q.push_back(mul_item);
            end
            if (v && ready_exp) begin
                if (ref_is_mul(opc, f3, f7)) begin
                    mul_left = 32;
                    mul_item = {PREG_TAG_W'(tag), a * b};
                end else begin
                    exp_q.push_back({PREG_TAG_W'(tag), ref_result(opc, f3, f7, a, b)});
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'h0, 3'd0, 7'h0, 32'd0, 32'd0, 0, g, 1'b0, "idle");
    endtask

    task automatic do_reset(input int n);
        reset           = 1'b1;
        alu_issue_valid = 1'b1;
        cdb_grant       = 1'b1;
        flush           = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            check("rst.ready", 64'(alu_ex_ready), 64'd0);
            check("rst.cdb", 64'(cdb_out), 64'd0);
            check("rst.state", 64'(dbg_state_o), 64'(IDLE));
        end
        exp_q.delete();
        mul_left        = 0;
        reset           = 1'b0;
        alu_issue_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [6:0]  r_opc;
    logic [6:0]  r_f7;
    logic [2:0]  r_f3;
    int          r_sel;

    // ---------------- main sequence ----------------
    initial begin
        n_vec           = 0;
        n_err           = 0;
        mul_left        = 0;
        mul_item        = '0;
        reset           = 1'b1;
        alu_issue_valid = 1'b0;
        alu_op_a        = '0;
        alu_op_b        = '0;
        alu_opcode      = '0;
        alu_funct3      = '0;
        alu_funct7      = '0;
        alu_p_dest      = '0;
        flush           = 1'b0;
        cdb_grant       = 1'b0;

        do_reset(3);
        idle(1, 1'b0);

        // ADD 10+20 tag 3, grant held: broadcast one cycle after transfer.
        cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd10, 32'd20, 3, 1'b1, 1'b0, "add");
        check("add.cdb", 64'(cdb_out), cdb_word(1'b1, 3, 32'd30));

        // SUB 5-7 tag 4 accepted in the grant cycle of the ADD; then held.
        cycle(1'b1, OPC_OP, 3'd0, 7'h20, 32'd5, 32'd7, 4, 1'b1, 1'b0, "sub");
        for (int i = 0; i < 3; i++) begin
            check("sub.cdb", 64'(cdb_out), cdb_word(1'b1, 4, 32'hFFFF_FFFE));
            cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd1, 32'd1, 7, 1'b0, 1'b0, "sub_hold");
        end
        check("sub.cdb_held", 64'(cdb_out), cdb_word(1'b1, 4, 32'hFFFF_FFFE));
        idle(1, 1'b1);

        // Shifts and compares.
        cycle(1'b1, OPC_OP, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 1, 1'b1, 1'b0, "sra");
        check("sra.data", 64'(cdb_out.data), 64'h F800_0000);
        cycle(1'b1, OPC_OP, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF, 2, 1'b1, 1'b0, "sltu");
        check("sltu.data", 64'(cdb_out.data), 64'd1);
        cycle(1'b1, OPC_OP, 3'd2, 7'h00, 32'd1, 32'hFFFF_FFFF, 2, 1'b1, 1'b0, "slt");
        check("slt.data", 64'(cdb_out.data), 64'd0);
        cycle(1'b1, OPC_OP_IMM, 3'd0, 7'h20, 32'd9, 32'd4, 3, 1'b1, 1'b0, "addi_f7");
        check("addi.data", 64'(cdb_out.data), 64'd13);
        cycle(1'b1, 7'b1100011, 3'd0, 7'h00, 32'd9, 32'd4, 10, 1'b1, 1'b0, "unsup");
        check("unsup.cdb", 64'(cdb_out), cdb_word(1'b1, 10, 32'd0));
        idle(1, 1'b1);

        // Back-to-back ADDs, no bubble.
        cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd1, 32'd2, 5, 1'b1, 1'b0, "b2b_5");
        check("b2b.first", 64'(cdb_out), cdb_word(1'b1, 5, 32'd3));
        cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd3, 32'd4, 6, 1'b1, 1'b0, "b2b_6");
        check("b2b.second", 64'(cdb_out), cdb_word(1'b1, 6, 32'd7));
        idle(1, 1'b1);
        check("b2b.drained", 64'(cdb_out.valid), 64'd0);

        // Flush while a result waits for grant.
        cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd2, 32'd2, 9, 1'b0, 1'b0, "fl_wb_add");
        cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd8, 32'd8, 14, 1'b0, 1'b1, "fl_wb");
        check("fl_wb.valid", 64'(cdb_out.valid), 64'd0);
        check("fl_wb.state", 64'(dbg_state_o), 64'(IDLE));
        idle(3, 1'b1);

`ifdef ALU_MUL_EN
        // MUL 7*6 tag 8: 32 cycles not ready, then broadcast.
        cycle(1'b1, OPC_OP, 3'd0, 7'h01, 32'd7, 32'd6, 8, 1'b1, 1'b0, "mul");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, OPC_OP, 3'd0, 7'h00, 32'd1, 32'd1, 15, 1'b1, 1'b0, "mul_busy");
        check("mul.cdb", 64'(cdb_out), cdb_word(1'b1, 8, 32'd42));
        idle(1, 1'b1);

        // Flush on the 10th busy cycle: the tag must never appear.
        cycle(1'b1, OPC_OP, 3'd0, 7'h01, 32'd3, 32'd5, 11, 1'b1, 1'b0, "mul_fl");
        idle(9, 1'b1);
        cycle(1'b0, 7'h0, 3'd0, 7'h0, 32'd0, 32'd0, 0, 1'b1, 1'b1, "mul_fl10");
        check("mul_fl.valid", 64'(cdb_out.valid), 64'd0);
        check("mul_fl.state", 64'(dbg_state_o), 64'(IDLE));
        idle(40, 1'b1);

        // Reset mid-multiply.
        cycle(1'b1, OPC_OP, 3'd0, 7'h01, 32'd9, 32'd9, 12, 1'b1, 1'b0, "mul_rst");
        idle(5, 1'b1);
        do_reset(1);
        idle(40, 1'b1);
`endif

        // Reset while a result waits in WB.
        cycle(1'b1, OPC_OP, 3'd7, 7'h00, 32'hF0F0, 32'hFF00, 13, 1'b0, 1'b0, "wb_rst");
        idle(1, 1'b0);
        do_reset(1);
        idle(2, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 700; i++) begin
            r_sel = $urandom_range(0, 9);
            r_opc = (r_sel < 5) ? OPC_OP : (r_sel < 8) ? OPC_OP_IMM : 7'($urandom);
            r_sel = $urandom_range(0, 3);
            r_f7  = (r_sel == 0) ? 7'h00 : (r_sel == 1) ? 7'h20 : (r_sel == 2) ? 7'h01 : 7'($urandom);
            r_f3  = 3'($urandom);
            cycle($urandom_range(0, 9) < 7, r_opc, r_f3, r_f7, pick_operand(), pick_operand(),
                  $urandom_range(0, (1 << PREG_TAG_W) - 1), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 39) == 0, "rand");
        end
        idle(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
